reset_seq_ctrl: RTL and testbench
=================================

Name: reset_seq_ctrl

Overview:
- Parametrised, synthesizable reset sequencer for the emulator-side (HDL) top.
- Replaces the fixed 2-cycle reset pulse with a configurable sequence:
  - synchronised release of the async reset
  - programmable hold
  - staggered per-domain release to NUM_DOMAINS child blocks (bus interfaces, aes cores)
- Adds a BFM-callable re-reset request, so the co-model side can reset the DUT mid-run without restarting emulation.

Parameters:
- NUM_DOMAINS, 2: number of active-high domain reset outputs.
- HOLD_CYCLES, 2: cycles all domains stay asserted after sync release; must be >= 1.
- STAGGER_CYCLES, 1: cycles between successive domain releases; 0 releases all domains on the same edge.
- SYNC_STAGES, 2: reset-deassertion synchroniser depth; must be >= 2.
- CNT_W, 8: sequencing counter width; must hold max(HOLD_CYCLES, STAGGER_CYCLES).

Ports:
- clk  input  1  global clock.
- resetN  input  1  asynchronous, active-low global reset.
- sw_reset_req  input  1  single-cycle pulse from the BFM; requests a full re-sequence.
- domain_resetH  output  NUM_DOMAINS  active-high reset per domain; bit 0 is released first.
- seq_busy  output  1  high while any domain is in reset.
- seq_done  output  1  high in RUN (all domains released).
- seq_count  output  8  number of completed sequences; saturates at 255.

Behaviour:
- Reset (resetN low), asynchronous and immediate:
  - domain_resetH = all ones, seq_busy = 1, seq_done = 0, seq_count = 0.
  - Synchroniser flops cleared; FSM goes to SYNC.
- Synchroniser: shifts in 1 on each clk edge after resetN rises; output goes high after SYNC_STAGES edges. Assertion is never synchronised.
- FSM states: SYNC, HOLD, RELEASE, RUN. All outputs are registered.
- SYNC -> HOLD:
  - Taken on the first edge where the synchroniser output is high.
  - Counter loads HOLD_CYCLES-1.
- HOLD:
  - All domains asserted; counter decrements each edge.
  - On the edge where the counter is 0: domain_resetH[0] clears and the FSM goes to RELEASE.
  - Counter loads STAGGER_CYCLES-1 (or goes straight to RUN if NUM_DOMAINS == 1).
- RELEASE:
  - Domain index idx starts at 1.
  - On each edge where the counter is 0, domain_resetH[idx] clears and the counter reloads.
  - When the last domain clears, the FSM enters RUN on that same edge.
  - STAGGER_CYCLES = 0: all domains clear on the HOLD exit edge and the FSM goes directly to RUN.
- RUN:
  - seq_done = 1, seq_busy = 0.
  - seq_count increments on the RUN entry edge and saturates at 255.
- sw_reset_req in RUN:
  - On the next edge: all domains reassert, seq_done = 0, FSM goes to HOLD, counter loads HOLD_CYCLES-1.
  - The synchroniser is not re-run.
- sw_reset_req in HOLD or RELEASE:
  - Already-released domains reassert and the HOLD count restarts from HOLD_CYCLES-1.
- sw_reset_req in SYNC, or while resetN is low: ignored.
- resetN asserted at any point mid-sequence: immediate async return to the reset values above.
- Release ordering invariants:
  - Domains release strictly in ascending index order.
  - A released domain never reasserts except via sw_reset_req or resetN.
  - seq_busy == |domain_resetH at all times.

Decomposition:
- Shared package (definitions): ulogic1 typedef, the seq_state_t enum {SYNC, HOLD, RELEASE, RUN}, and SEQ_COUNT_W = 8.
- Sub-module reset_sync (SYNC_STAGES-deep, async-assert / sync-deassert flop chain) is instantiated once.
- FSM, counter and domain register live in reset_seq_ctrl.

Test Plan:
- Power-on timing. Defaults; resetN low for 3 cycles, then high before edge E0.
  - Domains stay 2'b11 through E3.
  - domain_resetH = 2'b10 after E4.
  - 2'b00, seq_done = 1, seq_count = 1 after E5.
- Same-edge release. STAGGER_CYCLES = 0, NUM_DOMAINS = 4: after resetN release, all four bits clear on the same edge (E4); seq_done = 1 on that edge.
- Software reset from RUN. In RUN, pulse sw_reset_req for 1 cycle.
  - Next edge: domain_resetH = 2'b11, seq_done = 0.
  - Release 2'b10 after 2 more HOLD edges, then 2'b00 one edge later.
  - seq_count = 2.
- Software reset mid-release. sw_reset_req in the RELEASE cycle where domain_resetH = 2'b10 -> 2'b11 on the next edge; HOLD restarts at full length; seq_count increments only once, on final RUN entry.
- resetN mid-sequence. resetN low during HOLD -> outputs return to reset values combinationally-async, before the next clk edge; seq_count = 0.
- Counter saturation. 300 sw_reset_req cycles, each allowed to reach RUN -> seq_count stays 255; no wrap to 0.

Source files
------------

// File: rtl/reset_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reset_seq_ctrl_pkg
// Description : Shared types and constants for the reset sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package reset_seq_ctrl_pkg;

    // Single-bit logic alias used for internal control wires
    typedef logic ulogic1;

    // Width of the completed-sequence counter output
    localparam int SEQ_COUNT_W = 8;

    // Sequencer states, explicitly encoded
    typedef enum logic [1:0] {
        SYNC    = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } seq_state_t;

endpackage : reset_seq_ctrl_pkg
`default_nettype wire

// File: rtl/reset_seq_ctrl_sync.sv
`default_nettype none
// ============================================================================
// Module      : reset_sync
// Description : Asynchronous-assert / synchronous-deassert reset synchroniser.
//               The output rises SYNC_STAGES edges after resetN rises and
//               falls immediately when resetN falls.
// Revision    : 1.0 - initial release
// ============================================================================
module reset_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic resetN,
    output logic sync_out
);

    logic [SYNC_STAGES-1:0] r_chain;

    // Shift ones in after release; clear the whole chain on assertion
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sync_out = r_chain[SYNC_STAGES-1];

endmodule : reset_sync
`default_nettype wire

// File: rtl/reset_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : reset_seq_ctrl
// Description : Configurable reset sequencer. Synchronises the release of the
//               global async reset, holds all domains for HOLD_CYCLES, then
//               releases the domain resets in ascending order spaced by
//               STAGGER_CYCLES. A single-cycle sw_reset_req re-runs the hold
//               and release phases without re-synchronising.
// Revision    : 1.0 - initial release
// ============================================================================
module reset_seq_ctrl
    import reset_seq_ctrl_pkg::*;
#(
    parameter int NUM_DOMAINS    = 2,
    parameter int HOLD_CYCLES    = 2,
    parameter int STAGGER_CYCLES = 1,
    parameter int SYNC_STAGES    = 2,
    parameter int CNT_W          = 8
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   sw_reset_req,
    output logic [NUM_DOMAINS-1:0] domain_resetH,
    output logic                   seq_busy,
    output logic                   seq_done,
    output logic [7:0]             seq_count
);

    localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [CNT_W-1:0]       c_hold_load  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]       c_stag_load  = (STAGGER_CYCLES > 0) ? CNT_W'(STAGGER_CYCLES - 1) : '0;
    localparam logic [IDX_W-1:0]       c_first_idx  = (NUM_DOMAINS > 1) ? IDX_W'(1) : '0;
    localparam logic [IDX_W-1:0]       c_last_idx   = IDX_W'(NUM_DOMAINS - 1);
    localparam logic [SEQ_COUNT_W-1:0] c_count_max  = '1;
    // Everything released on the HOLD exit edge when there is nothing to stagger
    localparam bit                     c_bulk_release = (NUM_DOMAINS == 1) || (STAGGER_CYCLES == 0);

    ulogic1                   w_sync_rel;
    seq_state_t               r_state;
    logic [CNT_W-1:0]         r_cnt;
    logic [IDX_W-1:0]         r_idx;
    logic [NUM_DOMAINS-1:0]   r_domain;
    logic                     r_busy;
    logic                     r_done;
    logic [SEQ_COUNT_W-1:0]   r_count;

    reset_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_reset_sync (
        .clk      (clk),
        .resetN   (resetN),
        .sync_out (w_sync_rel)
    );

    // Sequencer FSM: state, hold/stagger counter, domain resets and status flags
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state  <= SYNC;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_domain <= '1;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
            r_count  <= '0;
        end else begin
            case (r_state)
                SYNC: begin
                    if (w_sync_rel) begin
                        r_state <= HOLD;
                        r_cnt   <= c_hold_load;
                    end
                end

                HOLD: begin
                    if (sw_reset_req) begin
                        r_cnt <= c_hold_load;
                    end else if (r_cnt == '0) begin
                        if (c_bulk_release) begin
                            r_domain <= '0;
                            r_state  <= RUN;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            if (r_count != c_count_max) begin
                                r_count <= r_count + 1'b1;
                            end
                        end else begin
                            r_domain[0] <= 1'b0;
                            r_state     <= RELEASE;
                            r_cnt       <= c_stag_load;
                            r_idx       <= c_first_idx;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                RELEASE: begin
                    if (sw_reset_req) begin
                        // Re-assert anything already released and restart the hold
                        r_domain <= '1;
                        r_state  <= HOLD;
                        r_cnt    <= c_hold_load;
                    end else if (r_cnt == '0) begin
                        r_domain[r_idx] <= 1'b0;
                        if (r_idx == c_last_idx) begin
                            r_state <= RUN;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            if (r_count != c_count_max) begin
                                r_count <= r_count + 1'b1;
                            end
                        end else begin
                            r_idx <= r_idx + 1'b1;
                            r_cnt <= c_stag_load;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                RUN: begin
                    if (sw_reset_req) begin
                        r_domain <= '1;
                        r_state  <= HOLD;
                        r_cnt    <= c_hold_load;
                        r_busy   <= 1'b1;
                        r_done   <= 1'b0;
                    end
                end

                default: begin
                    r_state <= SYNC;
                end
            endcase
        end
    end

    assign domain_resetH = r_domain;
    assign seq_busy      = r_busy;
    assign seq_done      = r_done;
    assign seq_count     = r_count;

endmodule : reset_seq_ctrl
`default_nettype wire

// File: tb/tb_reset_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_reset_seq_ctrl
// Description : Directed self-checking bench for reset_seq_ctrl. Instance A
//               uses default parameters; instance B has four domains released
//               on a single edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reset_seq_ctrl;

    typedef struct packed {
        logic [1:0] dom;
        logic       done;
        logic [7:0] cnt;
    } exp_t;

    logic       clk;
    logic       resetN;
    logic       sw_req_a;
    logic       sw_req_b;
    logic [1:0] dom_a;
    logic       busy_a;
    logic       done_a;
    logic [7:0] cnt_a;
    logic [3:0] dom_b;
    logic       busy_b;
    logic       done_b;
    logic [7:0] cnt_b;

    exp_t       sb_q[$];
    int         total;
    int         bad;
    logic [7:0] m_count;

    reset_seq_ctrl u_dut_a (
        .clk           (clk),
        .resetN        (resetN),
        .sw_reset_req  (sw_req_a),
        .domain_resetH (dom_a),
        .seq_busy      (busy_a),
        .seq_done      (done_a),
        .seq_count     (cnt_a)
    );

    reset_seq_ctrl #(
        .NUM_DOMAINS    (4),
        .STAGGER_CYCLES (0)
    ) u_dut_b (
        .clk           (clk),
        .resetN        (resetN),
        .sw_reset_req  (sw_req_b),
        .domain_resetH (dom_b),
        .seq_busy      (busy_b),
        .seq_done      (done_b),
        .seq_count     (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison point
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample shortly after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [1:0] dom, input logic done, input logic [7:0] cnt);
        exp_t e;
        e.dom  = dom;
        e.done = done;
        e.cnt  = cnt;
        sb_q.push_back(e);
    endtask

    // Pop the oldest expectation and compare all of instance A's outputs
    task automatic check_out(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_dom"},  32'(dom_a),  32'(e.dom));
            chk({tag, "_busy"}, 32'(busy_a), 32'(|e.dom));
            chk({tag, "_done"}, 32'(done_a), 32'(e.done));
            chk({tag, "_cnt"},  32'(cnt_a),  32'(e.cnt));
        end
    endtask

    task automatic step(input string tag, input logic [1:0] dom, input logic done, input logic [7:0] cnt);
        push_exp(dom, done, cnt);
        tick();
        check_out(tag);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        resetN   = 1'b0;
        sw_req_a = 1'b0;
        sw_req_b = 1'b0;

        // Power-on: reset held for three cycles
        repeat (3) tick();
        push_exp(2'b11, 1'b0, 8'd0);
        check_out("por_reset");
        chk("por_reset_b_dom", 32'(dom_b), 32'hF);

        @(negedge clk);
        resetN = 1'b1;

        // E0..E3: all domains still held
        for (int e = 0; e < 4; e++) begin
            step("por_hold", 2'b11, 1'b0, 8'd0);
            chk("same_edge_hold_b", 32'(dom_b), 32'hF);
        end
        // E4: domain 0 released on A, everything released on B
        step("por_e4", 2'b10, 1'b0, 8'd0);
        chk("same_edge_dom_b",  32'(dom_b),  32'h0);
        chk("same_edge_done_b", 32'(done_b), 32'h1);
        chk("same_edge_busy_b", 32'(busy_b), 32'h0);
        chk("same_edge_cnt_b",  32'(cnt_b),  32'h1);
        // E5: all released, RUN
        step("por_e5", 2'b00, 1'b1, 8'd1);

        // Software reset from RUN
        sw_req_a = 1'b1;
        step("swr_run_assert", 2'b11, 1'b0, 8'd1);
        sw_req_a = 1'b0;
        step("swr_run_hold", 2'b11, 1'b0, 8'd1);
        step("swr_run_rel0", 2'b10, 1'b0, 8'd1);
        step("swr_run_rel1", 2'b00, 1'b1, 8'd2);

        // Software reset in the middle of the release phase
        sw_req_a = 1'b1;
        step("swr_mid_start", 2'b11, 1'b0, 8'd2);
        sw_req_a = 1'b0;
        step("swr_mid_hold", 2'b11, 1'b0, 8'd2);
        step("swr_mid_rel0", 2'b10, 1'b0, 8'd2);
        sw_req_a = 1'b1;
        step("swr_mid_reassert", 2'b11, 1'b0, 8'd2);
        sw_req_a = 1'b0;
        step("swr_mid_hold2", 2'b11, 1'b0, 8'd2);
        step("swr_mid_rel0b", 2'b10, 1'b0, 8'd2);
        step("swr_mid_run", 2'b00, 1'b1, 8'd3);

        // resetN asserted during HOLD: outputs return before any clock edge
        sw_req_a = 1'b1;
        step("rstn_mid_hold", 2'b11, 1'b0, 8'd3);
        sw_req_a = 1'b0;
        #2;
        resetN = 1'b0;
        #1;
        push_exp(2'b11, 1'b0, 8'd0);
        check_out("rstn_async");
        tick();
        @(negedge clk);
        resetN = 1'b1;
        for (int e = 0; e < 4; e++) begin
            step("rstn_rerun_hold", 2'b11, 1'b0, 8'd0);
        end
        step("rstn_rerun_rel0", 2'b10, 1'b0, 8'd0);
        step("rstn_rerun_run", 2'b00, 1'b1, 8'd1);

        // Counter saturation over many software resets
        m_count = 8'd1;
        for (int n = 0; n < 300; n++) begin
            sw_req_a = 1'b1;
            tick();
            sw_req_a = 1'b0;
            m_count = (m_count == 8'd255) ? 8'd255 : m_count + 8'd1;
            push_exp(2'b00, 1'b1, m_count);
            begin
                bit seen;
                seen = 1'b0;
                for (int w = 0; w < 20 && !seen; w++) begin
                    tick();
                    if (done_a) seen = 1'b1;
                end
                if (!seen) begin
                    total++;
                    bad++;
                    $error("FAIL sat_timeout observed=no_done expected=done iter=%0d", n);
                end
            end
            check_out("sat_iter");
        end
        chk("sat_final", 32'(cnt_a), 32'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_reset_seq_ctrl
`default_nettype wire
